mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 64-bit data memory between two requesters: instruction fetch (read-only) and the memory stage (read/write).
//  Sequences each access (grant, issue, wait, respond) and bounds-checks the address against the memory depth.
//  Returns SADR-class errors to the requester.
//  Sits between the fetch/memory stages and the data memory array, replacing their direct array access.
// PARAMETERS
//  DEPTH      201  number of 64-bit words; legal word addresses are 0..DEPTH-1
//  LAT        1    memory read latency in cycles from mem_en to valid mem_rdata (1..7)
//  STARVE_MAX 3    consecutive contested dm grants before fetch is forced to win
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  if_req     in   1   fetch request; held until if_gnt
//  if_addr    in   64  fetch word address
//  if_gnt     out  1   fetch request accepted (1-cycle pulse)
//  if_rvalid  out  1   fetch response valid (1-cycle pulse)
//  if_rdata   out  64  fetch read data, valid with if_rvalid
//  if_err     out  1   fetch address out of range, valid with if_rvalid
//  dm_req     in   1   memory-stage request; held until dm_gnt
//  dm_we      in   1   1 = write, 0 = read
//  dm_addr    in   64  memory-stage word address
//  dm_wdata   in   64  write data
//  dm_gnt     out  1   memory-stage request accepted (1-cycle pulse)
//  dm_rvalid  out  1   memory-stage response / write ack (1-cycle pulse)
//  dm_rdata   out  64  read data (0 on writes and errors)
//  dm_err     out  1   address out of range (dmem_error), valid with dm_rvalid
//  busy       out  1   state != IDLE
//  mem_en     out  1   memory access strobe (1 cycle)
//  mem_we     out  1   write enable, qualified by mem_en
//  mem_addr   out  64  memory word address
//  mem_wdata  out  64  memory write data
//  mem_rdata  in   64  memory read data, valid LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; starve_cnt=0; latched owner/addr/data cleared. Applies mid-access: the in-flight access is dropped with no response.
//  FSM
//   IDLE: if any req, grant (gnt combinational this cycle), latch owner/we/addr/wdata.
//    Legal address -> ISSUE. addr >= DEPTH (full 64-bit compare) -> RESP with err=1 and no mem_en.
//   ISSUE (1 cycle): mem_en=1; mem_we=latched we; mem_addr and mem_wdata from latches.
//    -> WAIT, wait counter = LAT.
//   WAIT: count down; on the last WAIT cycle capture mem_rdata (reads only) -> RESP.
//   RESP (1 cycle): owner's rvalid=1, rdata/err driven from registers -> IDLE.
//    The next grant occurs no earlier than the following IDLE cycle.
//  Latency: grant at cycle 0 -> rvalid at cycle LAT+2 (LAT=1: cycle 3). Error: rvalid at cycle 1.
//  Throughput: one access per LAT+3 cycles.
//  Arbitration, only in IDLE:
//   dm wins over if, except when starve_cnt==STARVE_MAX, in which case if wins.
//   starve_cnt increments (saturating) on a dm grant while if_req=1; clears on any if grant.
//  Fetch is read-only: mem_we=0 whenever owner=fetch.
//  A req dropped before gnt is legal: no grant, no state change. Inputs are ignored outside IDLE.
//  Non-owner rvalid/rdata/err stay 0. rdata and err are 0 whenever rvalid=0.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//   Contested IDLE grants alternate round-robin, starting with dm after reset.
//   A 1-bit last-owner flag replaces the priority rule.
//   starve_cnt and STARVE_MAX are unused.
//  MEM_ARB_RR_EN undefined: fixed dm priority with the starvation override above.
// STRUCTURE
//  Package y86_mem_pkg:
//   state enum (IDLE/ISSUE/WAIT/RESP)
//   stat codes SAOK=0, SADR=1, SINS=2, SHLT=3
//   owner encoding OWN_IF/OWN_DM
//   default DEPTH
//  Sub-module mem_arb_pick: combinational winner select from (if_req, dm_req, starve_cnt or last-owner).
// TESTING
//  1. dm read addr 5, LAT=1, memory word 5 = 0x0A: dm_gnt@c0, mem_en@c1, dm_rvalid@c3, dm_rdata=0x0A, dm_err=0.
//  2. dm write addr 7 data 0x1234, then if read addr 7: mem_we=1 on the first access; if_rdata=0x1234; if_err=0.
//  3. dm read addr 201: dm_rvalid@c1, dm_err=1, dm_rdata=0, no mem_en pulse.
//  4. if_req and dm_req held continuously, STARVE_MAX=3: grant order dm,dm,dm,if,dm,dm,dm,if.
//  5. Same as 4 with MEM_ARB_RR_EN defined: grant order dm,if,dm,if.
//  6. Assert rst_n=0 during WAIT: all outputs 0 immediately; after release, busy=0 and no rvalid ever appears for the dropped access.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Used by mem_port_arbiter and mem_arb_pick; MEM_ARB_RR_EN selects round-robin arbitration.
package y86_mem_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Which requester owns the access in flight
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Y86 status codes; an out-of-range address is reported as SADR
   localparam logic [1:0] SAOK = 2'd0;
   localparam logic [1:0] SADR = 2'd1;
   localparam logic [1:0] SINS = 2'd2;
   localparam logic [1:0] SHLT = 2'd3;

   localparam int unsigned DEFAULT_DEPTH = 201;

   // Width of the starvation counter (STARVE_MAX must fit)
   localparam int unsigned STARVE_W = 8;

   // Full 64-bit bounds check of a word address against the memory depth
   function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
      return addr < 64'(depth);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters (fetch, memory stage), the arbiter and the data memory array.
// slave = arbiter view, master = environment view (requesters plus memory).
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [63:0] if_rdata;
   logic        if_err;

   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [63:0] dm_rdata;
   logic        dm_err;

   logic        busy;

   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_gnt, dm_rvalid, dm_rdata, dm_err,
      output busy,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
      input  busy,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between fetch and memory stage.
// Default: memory stage priority with a starvation override for fetch.
// MEM_ARB_RR_EN: contested requests alternate based on the last owner.
module mem_arb_pick
   import y86_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                if_req_i,
   input  logic                dm_req_i,
`ifdef MEM_ARB_RR_EN
   input  owner_e              last_owner_i,
`else
   input  logic [STARVE_W-1:0] starve_cnt_i,
`endif
   output logic                valid_o,
   output owner_e              owner_o
);

   // Pick the owner of the next access; an uncontested request always wins
   always_comb begin
      valid_o = if_req_i | dm_req_i;
      owner_o = OWN_DM;
      if (if_req_i && !dm_req_i) begin
         owner_o = OWN_IF;
      end else if (if_req_i && dm_req_i) begin
`ifdef MEM_ARB_RR_EN
         owner_o = (last_owner_i == OWN_DM) ? OWN_IF : OWN_DM;
`else
         owner_o = (starve_cnt_i == STARVE_W'(STARVE_MAX)) ? OWN_IF : OWN_DM;
`endif
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit data memory between instruction fetch (read-only)
// and the memory stage (read/write). Each access runs IDLE -> ISSUE -> WAIT -> RESP;
// out-of-range addresses skip the memory and respond with err (SADR) one cycle after grant.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of dm priority + starvation override.
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned LAT        = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   state_e      state_q;
   owner_e      owner_q;
   logic        we_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [2:0]  wait_q;
   logic        mem_en_q;
   logic        mem_we_q;
   logic        if_rvalid_q;
   logic [63:0] if_rdata_q;
   logic        if_err_q;
   logic        dm_rvalid_q;
   logic [63:0] dm_rdata_q;
   logic        dm_err_q;
`ifdef MEM_ARB_RR_EN
   owner_e      last_owner_q;
`else
   logic [STARVE_W-1:0] starve_q;
`endif

   logic        pickValid;
   owner_e      pickOwner;
   logic        grantValid;
   logic [63:0] gntAddr;
   logic        gntWe;
   logic [63:0] gntWdata;
   logic        gntLegal;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .if_req_i     (bus.if_req),
      .dm_req_i     (bus.dm_req),
`ifdef MEM_ARB_RR_EN
      .last_owner_i (last_owner_q),
`else
      .starve_cnt_i (starve_q),
`endif
      .valid_o      (pickValid),
      .owner_o      (pickOwner)
   );

   // Grant decode: only in IDLE, and never while reset is held; fetch never writes
   always_comb begin
      grantValid = rst_n && (state_q == IDLE) && pickValid;
      gntAddr    = (pickOwner == OWN_DM) ? bus.dm_addr : bus.if_addr;
      gntWe      = (pickOwner == OWN_DM) && bus.dm_we;
      gntWdata   = (pickOwner == OWN_DM) ? bus.dm_wdata : 64'd0;
      gntLegal   = addr_in_range(gntAddr, DEPTH);
   end

   assign bus.if_gnt    = grantValid && (pickOwner == OWN_IF);
   assign bus.dm_gnt    = grantValid && (pickOwner == OWN_DM);
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_err    = if_err_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_err    = dm_err_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // Access sequencer: latches the granted request, strobes the memory, waits LAT cycles, responds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         we_q         <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         wait_q       <= 3'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         if_rvalid_q  <= 1'b0;
         if_rdata_q   <= 64'd0;
         if_err_q     <= 1'b0;
         dm_rvalid_q  <= 1'b0;
         dm_rdata_q   <= 64'd0;
         dm_err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= OWN_IF;
`else
         starve_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grantValid) begin
                  owner_q <= pickOwner;
                  we_q    <= gntWe;
                  addr_q  <= gntAddr;
                  wdata_q <= gntWdata;
`ifdef MEM_ARB_RR_EN
                  last_owner_q <= pickOwner;
`else
                  if (pickOwner == OWN_IF) begin
                     starve_q <= '0;
                  end else if (bus.if_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
                     starve_q <= starve_q + 1'b1;
                  end
`endif
                  if (gntLegal) begin
                     state_q  <= ISSUE;
                     mem_en_q <= 1'b1;
                     mem_we_q <= gntWe;
                  end else begin
                     state_q <= RESP;
                     if (pickOwner == OWN_DM) begin
                        dm_rvalid_q <= 1'b1;
                        dm_err_q    <= 1'b1;
                     end else begin
                        if_rvalid_q <= 1'b1;
                        if_err_q    <= 1'b1;
                     end
                  end
               end
            end
            ISSUE: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               wait_q   <= 3'(LAT);
               state_q  <= WAIT;
            end
            WAIT: begin
               if (wait_q <= 3'd1) begin
                  state_q <= RESP;
                  if (owner_q == OWN_DM) begin
                     dm_rvalid_q <= 1'b1;
                     dm_rdata_q  <= we_q ? 64'd0 : bus.mem_rdata;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= bus.mem_rdata;
                  end
               end else begin
                  wait_q <= wait_q - 3'd1;
               end
            end
            RESP: begin
               if_rvalid_q <= 1'b0;
               if_rdata_q  <= 64'd0;
               if_err_q    <= 1'b0;
               dm_rvalid_q <= 1'b0;
               dm_rdata_q  <= 64'd0;
               dm_err_q    <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
